mem_burst_master: RTL

- Initiator for the on-chip single-port RAM wrapper's available/output_available handshake.
- Accepts host load/store burst requests, issues one word transaction at a time with incrementing address, and streams write data in and read data out.
- Sits between the CPU/DMA side and the RAM wrapper; adds completion detection, per-word timeout and burst sequencing.

---
 rtl/mem_pkg.sv | 19 +
 rtl/mem_burst_master.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the RAM burst initiator: default widths and FSM states.
// RAM-side handshake naming: mem_available (request pulse, one cycle per word),
// mem_output_available (completion level from RAM, edge-detected by the master),
// mem_address / mem_write / mem_read / mem_we.
package mem_pkg;

    localparam int MEM_ADDR_W  = 14;
    localparam int MEM_DATA_W  = 32;
    localparam int MEM_LEN_W   = 8;
    localparam int MEM_TIMEOUT = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

endpackage

// File: rtl/mem_burst_master.sv
// Burst initiator for the single-port RAM wrapper: one word transaction at a
// time, incrementing address, completion on the RAM's rising completion level,
// per-word timeout with sticky error.
module mem_burst_master
    import mem_pkg::*;
#(
    parameter int ADDR_W  = MEM_ADDR_W,
    parameter int DATA_W  = MEM_DATA_W,
    parameter int LEN_W   = MEM_LEN_W,
    parameter int TIMEOUT = MEM_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write,
    output logic              mem_we,
    output logic              mem_available,
    input  logic [DATA_W-1:0] mem_read,
    input  logic              mem_output_available
);

    localparam int TO_W = $clog2(TIMEOUT + 1);
    // Last WAIT cycle index before abort; counter starts at 0 on WAIT entry.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_e            state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  rem_q;
    logic              we_q;
    logic [TO_W-1:0]   to_cnt;
    logic              oa_q;

    logic accept;
    logic issue_go;
    logic cmpl;
    logic to_hit;
    logic last_word;

    // Gate ready with reset so the host never sees ready while reset is held.
    assign req_ready   = rst_n && (state == ST_IDLE);
    assign accept      = req_valid && req_ready;
    assign wr_ready    = (state == ST_ISSUE) && we_q && wr_valid;
    // Reads issue immediately; writes wait for a data word.
    assign issue_go    = (state == ST_ISSUE) && (!we_q || wr_valid);
    // Only a low->high transition counts, so a level left high is ignored.
    assign cmpl        = (state == ST_WAIT) && mem_output_available && !oa_q;
    // Completion wins over expiry in the same cycle.
    assign to_hit      = (state == ST_WAIT) && !cmpl && (to_cnt == TO_LAST);
    assign last_word   = (rem_q == '0);
    assign mem_address = addr_q;
    assign mem_we      = we_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (accept)   state_nxt = ST_ISSUE;
            ST_ISSUE: if (issue_go) state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (cmpl)        state_nxt = last_word ? ST_IDLE : ST_GAP;
                else if (to_hit) state_nxt = ST_IDLE;
            end
            ST_GAP:   state_nxt = ST_ISSUE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Burst datapath: request latch, RAM strobe, read return, timeout, error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q        <= '0;
            rem_q         <= '0;
            we_q          <= 1'b0;
            to_cnt        <= '0;
            oa_q          <= 1'b0;
            mem_available <= 1'b0;
            mem_write     <= '0;
            rd_valid      <= 1'b0;
            rd_data       <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            mem_available <= 1'b0;
            rd_valid      <= 1'b0;
            done          <= 1'b0;
            oa_q          <= mem_output_available;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        addr_q <= req_addr;
                        rem_q  <= req_len;
                        we_q   <= req_we;
                        err    <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    if (issue_go) begin
                        mem_available <= 1'b1;
                        to_cnt        <= '0;
                        if (we_q) mem_write <= wr_data;
                    end
                end
                ST_WAIT: begin
                    if (cmpl) begin
                        if (!we_q) begin
                            rd_data  <= mem_read;
                            rd_valid <= 1'b1;
                        end
                        if (last_word) begin
                            done <= 1'b1;
                        end else begin
                            addr_q <= addr_q + ADDR_W'(1);
                            rem_q  <= rem_q - LEN_W'(1);
                        end
                    end else if (to_hit) begin
                        err  <= 1'b1;
                        done <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
